// File: rtl/dmem_responder_if.sv
// Load/store request bus between the processor memory stage and the data responder.
interface dmem_responder_if #(
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned AWIDTH_MEM = 32
);
  logic                    d_i_req;
  logic                    d_i_we;
  logic [AWIDTH_MEM-1:0]   d_i_addr;
  logic [DWIDTH-1:0]       d_i_wdata;
  logic [DWIDTH/8-1:0]     d_i_be;
  logic                    d_o_ack;
  logic [DWIDTH-1:0]       d_o_rdata;
  logic                    d_o_err;
  logic                    d_o_busy;

  modport master (
    output d_i_req, d_i_we, d_i_addr, d_i_wdata, d_i_be,
    input  d_o_ack, d_o_rdata, d_o_err, d_o_busy
  );

  modport slave (
    input  d_i_req, d_i_we, d_i_addr, d_i_wdata, d_i_be,
    output d_o_ack, d_o_rdata, d_o_err, d_o_busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, programmable wait states, single-cycle ack
// with read data or error, backed by an internal word array.
module dmem_responder #(
  parameter int unsigned DWIDTH      = 32,
  parameter int unsigned AWIDTH_MEM  = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic             d_clk,
  input  logic             d_rst,
  dmem_responder_if.slave  bus
);
  localparam int unsigned NB = DWIDTH / 8;
  localparam int unsigned IW = $clog2(DEPTH);
  localparam logic [3:0]  WaitInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q;
  logic [AWIDTH_MEM-1:0] addr_q;
  logic [DWIDTH-1:0]     wdata_q;
  logic [NB-1:0]         be_q;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [DWIDTH-1:0]     rdata_q, rdata_d;
  logic                  latch_en;
  logic                  mem_we;
  logic                  addr_hi;
  logic                  acc_err;
  logic [IW-1:0]         idx;

  // Contents start at zero and survive reset.
  logic [DWIDTH-1:0] mem [DEPTH] = '{default: '0};

  if (AWIDTH_MEM > IW + 2) begin : g_hi
    assign addr_hi = |addr_q[AWIDTH_MEM-1:IW+2];
  end else begin : g_nohi
    assign addr_hi = 1'b0;
  end

  assign idx     = addr_q[IW+1:2];
  assign acc_err = (addr_q[1:0] != 2'b00) || addr_hi;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    mem_we   = 1'b0;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (bus.d_i_req) begin
          latch_en = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = StAccess;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) state_d = StAccess;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StAccess: begin
        ack_d   = 1'b1;
        err_d   = acc_err;
        rdata_d = (we_q || acc_err) ? '0 : mem[idx];
        mem_we  = we_q && !acc_err;
        state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge d_clk or posedge d_rst) begin
    if (d_rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Request fields are sampled once; later input changes are ignored.
  always_ff @(posedge d_clk or posedge d_rst) begin
    if (d_rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (latch_en) begin
      we_q    <= bus.d_i_we;
      addr_q  <= bus.d_i_addr;
      wdata_q <= bus.d_i_wdata;
      be_q    <= bus.d_i_be;
    end
  end

  always_ff @(posedge d_clk) begin
    if (mem_we) begin
      for (int k = 0; k < NB; k++) begin
        if (be_q[k]) mem[idx][k*8 +: 8] <= wdata_q[k*8 +: 8];
      end
    end
  end

  assign bus.d_o_ack   = ack_q;
  assign bus.d_o_err   = err_q;
  assign bus.d_o_rdata = rdata_q;
  assign bus.d_o_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three builds (WAIT_CYCLES 1, 0, 5), vector table, corner sequences
// and random traffic against a word-array reference model.
module tb_dmem_responder;
  localparam int unsigned WC [3] = '{1, 0, 5};

  logic d_clk = 1'b0;
  logic d_rst = 1'b1;
  always #5 d_clk = ~d_clk;

  logic        req   [3];
  logic        we    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  be    [3];
  logic        ack   [3];
  logic        err   [3];
  logic        busy  [3];
  logic [31:0] rdata [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder_if #(.DWIDTH(32), .AWIDTH_MEM(32)) bus ();
    dmem_responder #(
      .DWIDTH(32), .AWIDTH_MEM(32), .DEPTH(256), .WAIT_CYCLES(WC[g])
    ) u_dut (
      .d_clk(d_clk),
      .d_rst(d_rst),
      .bus  (bus)
    );
    assign bus.d_i_req   = req[g];
    assign bus.d_i_we    = we[g];
    assign bus.d_i_addr  = addr[g];
    assign bus.d_i_wdata = wdata[g];
    assign bus.d_i_be    = be[g];
    assign ack[g]        = bus.d_o_ack;
    assign err[g]        = bus.d_o_err;
    assign busy[g]       = bus.d_o_busy;
    assign rdata[g]      = bus.d_o_rdata;
  end

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] mm [3][256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Reference: word array, byte-lane merge, error on misalignment or index past the end.
  function automatic void model_apply(input int d, input logic w, input logic [31:0] a,
                                      input logic [31:0] wd, input logic [3:0] b,
                                      output logic [31:0] rd, output logic er);
    er = (a[1:0] != 2'b00) || ((a >> 2) >= 256);
    rd = 32'h0;
    if (!er) begin
      if (w) begin
        for (int k = 0; k < 4; k++) if (b[k]) mm[d][a >> 2][k*8 +: 8] = wd[k*8 +: 8];
      end else begin
        rd = mm[d][a >> 2];
      end
    end
  endfunction

  // Called #1 after a rising edge with the DUT idle; returns #1 after the edge ending RESP.
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] b, output logic [31:0] rd, output logic er,
                      output int lat);
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
    lat = -1;
    rd  = 32'hx;
    er  = 1'bx;
    for (int k = 0; k < 40; k++) begin
      @(posedge d_clk); #1;
      if (k == 0) begin
        we[d] = ~w; addr[d] = ~a; wdata[d] = ~wd; be[d] = ~b;
      end
      if (ack[d]) begin
        lat = k;
        rd  = rdata[d];
        er  = err[d];
        break;
      end
    end
    req[d] = 1'b0;
    @(posedge d_clk); #1;
    check($sformatf("ack_pulse d%0d", d), {31'd0, ack[d]}, 32'd0);
  endtask

  task automatic do_vec(input string tag, input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] b,
                        input logic [31:0] exp_rd, input logic exp_er);
    logic [31:0] rd;
    logic        er;
    int          lat;
    xfer(d, w, a, wd, b, rd, er, lat);
    check($sformatf("%s latency d%0d", tag, d), lat, WC[d] + 1);
    check($sformatf("%s rdata d%0d a=%h", tag, d, a), rd, exp_rd);
    check($sformatf("%s err d%0d a=%h", tag, d, a), {31'd0, er}, {31'd0, exp_er});
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [31:0] rd_m;
    logic        er_m;
    int          ack_edges[$];
    int          idle_cnt;
    bit          seen;

    tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
    tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{1'b0, 32'h0000_0013, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};
    tbl[3]  = '{1'b0, 32'h0000_0400, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};
    tbl[4]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0};
    tbl[5]  = '{1'b1, 32'h0000_0010, 32'h0000_AB00, 4'h2, 32'h0000_0000, 1'b0};
    tbl[6]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_ABEF, 1'b0};
    tbl[7]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
    tbl[8]  = '{1'b1, 32'h0000_0012, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1};
    tbl[9]  = '{1'b1, 32'h0000_03FC, 32'h0BAD_F00D, 4'hF, 32'h0000_0000, 1'b0};
    tbl[10] = '{1'b0, 32'h0000_03FC, 32'h0000_0000, 4'h0, 32'h0BAD_F00D, 1'b0};
    tbl[11] = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000, 1'b0};
    tbl[12] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0};

    for (int d = 0; d < 3; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0; be[d] = '0;
      for (int i = 0; i < 256; i++) mm[d][i] = 32'h0;
    end

    repeat (3) @(posedge d_clk);
    #1 d_rst = 1'b0;
    @(posedge d_clk); #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset ack d%0d", d), {31'd0, ack[d]}, 32'd0);
      check($sformatf("reset err d%0d", d), {31'd0, err[d]}, 32'd0);
      check($sformatf("reset busy d%0d", d), {31'd0, busy[d]}, 32'd0);
      check($sformatf("reset rdata d%0d", d), rdata[d], 32'd0);
    end

    // Directed table on every build.
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 13; i++) begin
        model_apply(d, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, rd_m, er_m);
        do_vec($sformatf("tbl%0d", i), d, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be,
               tbl[i].exp_rd, tbl[i].exp_err);
      end
    end

    // Request held high across transfers: acks WAIT_CYCLES+3 apart, one idle cycle between.
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10; wdata[0] = '0; be[0] = '0;
    idle_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge d_clk); #1;
      if (ack[0]) begin
        ack_edges.push_back(k);
        check("held rdata", rdata[0], 32'hDEAD_BEEF);
      end
      if (!busy[0] && ack_edges.size() == 1) idle_cnt++;
    end
    req[0] = 1'b0;
    repeat (3) @(posedge d_clk);
    #1;
    check("held ack count", ack_edges.size(), 3);
    if (ack_edges.size() >= 2) check("held ack spacing", ack_edges[1] - ack_edges[0], 4);
    check("held idle cycles", idle_cnt, 1);
    check("held first ack edge", (ack_edges.size() > 0) ? ack_edges[0] : -1, 2);

    // Reset during WAIT of a write: dropped, outputs cleared at once, no ack.
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h1234_5678; be[0] = 4'hF;
    @(posedge d_clk); #1;
    check("rst pre busy", {31'd0, busy[0]}, 32'd1);
    #2 d_rst = 1'b1;
    #1;
    check("rst ack", {31'd0, ack[0]}, 32'd0);
    check("rst busy", {31'd0, busy[0]}, 32'd0);
    check("rst rdata", rdata[0], 32'd0);
    check("rst err", {31'd0, err[0]}, 32'd0);
    req[0] = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge d_clk); #1;
      if (ack[0]) seen = 1'b1;
    end
    check("rst no ack", {31'd0, seen}, 32'd0);
    d_rst = 1'b0;
    @(posedge d_clk); #1;
    model_apply(0, 1'b0, 32'h20, 32'h0, 4'h0, rd_m, er_m);
    do_vec("after_rst", 0, 1'b0, 32'h20, 32'h0, 4'h0, rd_m, er_m);
    model_apply(0, 1'b0, 32'h10, 32'h0, 4'h0, rd_m, er_m);
    do_vec("after_rst", 0, 1'b0, 32'h10, 32'h0, 4'h0, rd_m, er_m);

    // Random traffic against the reference model.
    for (int i = 0; i < 90; i++) begin
      int          d;
      int          r;
      logic        w;
      logic [31:0] a;
      logic [31:0] wd;
      logic [3:0]  b;
      d  = $urandom_range(0, 2);
      r  = $urandom_range(0, 9);
      w  = 1'($urandom_range(0, 1));
      wd = $urandom;
      b  = 4'($urandom_range(0, 15));
      a  = 32'($urandom_range(0, 15)) << 2;
      if (r == 0) a = $urandom | 32'h0000_0400;
      else if (r == 1) a = a | 32'($urandom_range(1, 3));
      else if (r == 2) a = 32'h3FC;
      model_apply(d, w, a, wd, b, rd_m, er_m);
      do_vec($sformatf("rnd%0d", i), d, w, a, wd, b, rd_m, er_m);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the target end of the processor's load/store request interface.
- Accepts one word-aligned read or write request at a time, inserts a programmable number of wait states and performs the access on an internal word array.
- Returns a single-cycle acknowledge with read data or an error flag.
- Sits between the processor's memory stage and the data store; lets the pipeline's stall handling be exercised against non-zero memory latency.

Parameters:
- DWIDTH, 32, data word width in bits (multiple of 8).
- AWIDTH_MEM, 32, request byte-address width.
- DEPTH, 256, number of words in the array (power of 2, >= 2).
- WAIT_CYCLES, 1, wait states inserted before the access (0..15).

Ports:
- d_clk  input  1  clock, rising-edge.
- d_rst  input  1  reset, asynchronous, active-high.
- d_i_req  input  1  request valid; held with all fields stable until d_o_ack.
- d_i_we  input  1  1 = write, 0 = read.
- d_i_addr  input  AWIDTH_MEM  byte address.
- d_i_wdata  input  DWIDTH  write data.
- d_i_be  input  DWIDTH/8  byte enables for writes; bit k covers byte lane k.
- d_o_ack  output  1  one-cycle completion pulse.
- d_o_rdata  output  DWIDTH  read data; valid with d_o_ack.
- d_o_err  output  1  error flag; valid with d_o_ack.
- d_o_busy  output  1  high while a request is in progress (any state other than IDLE).

Behaviour:
- One clock: d_clk. Reset: d_rst, asynchronous, active-high.
- Reset values: d_o_ack=0, d_o_err=0, d_o_rdata=0, d_o_busy=0; state=IDLE; wait counter=0.
- Array contents are zero at time 0 and are not cleared by d_rst.
- States:
  - IDLE: at a rising edge with d_i_req=1, latch we/addr/wdata/be. Go to WAIT with counter=WAIT_CYCLES-1, or straight to ACCESS if WAIT_CYCLES=0.
  - WAIT: decrement the counter each edge; at the edge where counter==0, go to ACCESS.
  - ACCESS: perform the operation on the latched fields and register d_o_ack=1 with rdata/err; go to RESP.
  - RESP: d_o_ack is high for exactly this cycle; next edge clears ack and err and returns to IDLE.
- Latency: request accepted at edge E0; d_o_ack is high in the cycle after edge E0+WAIT_CYCLES+1. WAIT_CYCLES=1 gives ack after E2.
- Throughput: one transfer per WAIT_CYCLES+3 cycles. A request is never accepted in RESP; d_i_req still high in IDLE is a new request.
- Addressing:
  - Word index = d_i_addr >> 2.
  - Error when d_i_addr[1:0] != 0 or index >= DEPTH.
  - On error: no array write, d_o_rdata=0, d_o_err=1 alongside d_o_ack.
- Write (no error): byte lane k of the word is replaced by d_i_wdata lane k only where be[k]=1. be=0 is a legal no-op write; ack is still given with err=0. d_o_rdata=0 on writes.
- Read (no error): d_o_rdata = full word, d_i_be ignored.
- d_o_rdata holds its value until the next ACCESS or reset.
- Inputs that change while busy are ignored; only the latched copy is used.
- Reset mid-operation (any state): return immediately to IDLE with reset outputs. An access not yet performed is dropped with no array write and no ack.
- Read-after-write to the same word in back-to-back transfers returns the newly written data.

Test Plan:
- Reset, then write addr=0x00000010, wdata=0xDEADBEEF, be=0xF; then read 0x10 -> ack pulse 1 cycle, at edge E0+2 for each transfer (WAIT_CYCLES=1); rdata=0xDEADBEEF, err=0.
- Partial write be=0x2 with wdata=0x0000AB00 to word 0x10 holding 0xDEADBEEF; read back -> 0xDEADABEF.
- Misaligned read addr=0x00000013 and out-of-range addr=0x00000400 (DEPTH=256) -> ack with err=1, rdata=0; word 0x10 still reads 0xDEADBEEF.
- d_i_req held high across two transfers -> busy low exactly one cycle (IDLE) between them; acks 4 cycles apart.
- Assert d_rst during WAIT of a write of 0x12345678 to 0x20 -> ack never asserted, outputs zero immediately; subsequent read of 0x20 -> 0x00000000.
- WAIT_CYCLES=0 and WAIT_CYCLES=5 builds -> ack after E1 and after E6 respectively; data results identical to the first scenario.
